// File: rtl/sweep_analyzer.sv
// Per-step peak-magnitude analyzer for a stepped frequency sweep.
// One result per step is offered on a valid/ready register; overflows are flagged.
module sweep_analyzer #(
   parameter int unsigned DWELL_CYCLES  = 50_000,
   parameter int unsigned SETTLE_CYCLES = 1_000,
   parameter int unsigned N_STEPS       = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_data,
   input  logic        i_valid,
   output logic        o_busy,
   output logic        o_res_valid,
   output logic [15:0] o_res_peak,
   output logic [15:0] o_res_idx,
   input  logic        i_res_ready,
   output logic        o_done,
   output logic        o_overrun
);

   localparam int unsigned CW = $clog2(DWELL_CYCLES + 1);
   localparam logic [CW-1:0] CNT_SET_END = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_LAST    = CW'(DWELL_CYCLES - 1);
   localparam logic [15:0]   IDX_LAST    = 16'(N_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      NEXT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CW-1:0] cnt;
   logic [15:0]   idx;
   logic [15:0]   peak;
   logic [15:0]   mag;
   logic          last_step;
   logic          sweep_start;
   logic          step_end;
   logic          cnt_inc;
   logic          pk_upd;
   logic          res_ld;

   // |x| with the single unrepresentable value clamped to 32767
   always_comb begin
      mag = i_data;
      if (i_data[15]) begin
         if (i_data == 16'h8000) mag = 16'h7fff;
         else                    mag = ~i_data + 16'd1;
      end
   end

   assign last_step = (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      sweep_start = 1'b0;
      step_end    = 1'b0;
      cnt_inc     = 1'b0;
      pk_upd      = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               sweep_start = 1'b1;
               if (SETTLE_CYCLES == 0) state_nxt = MEASURE;
               else                    state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            cnt_inc = 1'b1;
            if (cnt == CNT_SET_END) state_nxt = MEASURE;
         end
         MEASURE: begin
            cnt_inc = 1'b1;
            pk_upd  = i_valid;
            if (cnt == CNT_LAST) state_nxt = NEXT;
         end
         NEXT: begin
            step_end = 1'b1;
            if (last_step)               state_nxt = IDLE;
            else if (SETTLE_CYCLES == 0) state_nxt = MEASURE;
            else                         state_nxt = SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a held result may be replaced only when it is consumed on the same edge
   assign res_ld = step_end && (!o_res_valid || i_res_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         peak        <= '0;
         o_res_valid <= 1'b0;
         o_res_peak  <= '0;
         o_res_idx   <= '0;
         o_overrun   <= 1'b0;
      end else begin
         if (sweep_start || step_end) cnt <= '0;
         else if (cnt_inc)            cnt <= cnt + 1'b1;

         if (sweep_start)   idx <= '0;
         else if (step_end) idx <= idx + 16'd1;

         if (sweep_start || step_end)   peak <= '0;
         else if (pk_upd && mag > peak) peak <= mag;

         if (res_ld) begin
            o_res_valid <= 1'b1;
            o_res_peak  <= peak;
            o_res_idx   <= idx;
         end else if (o_res_valid && i_res_ready) begin
            o_res_valid <= 1'b0;
         end

         if (sweep_start)
            o_overrun <= 1'b0;
         else if (step_end && o_res_valid && !i_res_ready)
            o_overrun <= 1'b1;
      end
   end

   assign o_busy = (state != IDLE);
   assign o_done = step_end && last_step;

endmodule

// File: tb/tb_sweep_analyzer.sv
// Directed bench for sweep_analyzer: table of whole-sweep scenarios
// plus hand sequences for reset and start-while-busy.
module tb_sweep_analyzer;

   localparam int D    = 8;
   localparam int S    = 2;
   localparam int N    = 3;
   localparam int STEP = D + 1;
   localparam int LEN  = N * STEP;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [15:0] i_data;
   logic        i_valid;
   logic        i_res_ready;
   logic        o_busy;
   logic        o_res_valid;
   logic [15:0] o_res_peak;
   logic [15:0] o_res_idx;
   logic        o_done;
   logic        o_overrun;

   sweep_analyzer #(
      .DWELL_CYCLES (D),
      .SETTLE_CYCLES(S),
      .N_STEPS      (N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_busy     (o_busy),
      .o_res_valid(o_res_valid),
      .o_res_peak (o_res_peak),
      .o_res_idx  (o_res_idx),
      .i_res_ready(i_res_ready),
      .o_done     (o_done),
      .o_overrun  (o_overrun)
   );

   always #5 clk = ~clk;

   // mode: 0 ready always, 1 ready only on NEXT cycles, 2 ready never
   typedef struct {
      logic [0:2][0:7][15:0] d;
      logic [0:2][0:7]       v;
      int                    mode;
      logic [0:2][15:0]      pk;
      int                    n_res;
      logic                  ovr;
   } vec_t;

   vec_t tbl [5];
   int   checks   = 0;
   int   failures = 0;
   int   n_got;
   int   r_idx [8];
   int   r_pk  [8];
   int   r_cyc [8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int c);
      if (o_res_valid && i_res_ready && n_got < 8) begin
         r_idx[n_got] = int'(o_res_idx);
         r_pk[n_got]  = int'(o_res_peak);
         r_cyc[n_got] = c;
         n_got++;
      end
   endtask

   task automatic run_sweep(input vec_t t, input int id);
      int busy_err;
      int done_err;
      int stab_err;
      int h_idx;
      int h_pk;
      int step;
      int pos;
      busy_err = 0;
      done_err = 0;
      stab_err = 0;
      h_idx    = 0;
      h_pk     = 0;
      n_got    = 0;
      i_start     = 1'b1;
      i_valid     = 1'b1;
      i_data      = 16'd31000;
      i_res_ready = (t.mode == 0);
      tick();
      for (int c = 1; c <= LEN; c++) begin
         step    = (c - 1) / STEP;
         pos     = (c - 1) % STEP;
         i_start = 1'b0;
         if (pos < D) begin
            i_data  = t.d[step][pos];
            i_valid = t.v[step][pos];
         end else begin
            i_data  = 16'd31000;
            i_valid = 1'b1;
         end
         case (t.mode)
            0:       i_res_ready = 1'b1;
            1:       i_res_ready = (pos == D);
            default: i_res_ready = 1'b0;
         endcase
         if (c == 1) begin
            check($sformatf("v%0d_busy_start", id), int'(o_busy), 1);
            check($sformatf("v%0d_ovr_start", id), int'(o_overrun), 0);
            check($sformatf("v%0d_rv_start", id), int'(o_res_valid), 0);
         end
         if (c == 10)
            check($sformatf("v%0d_ovr_c10", id), int'(o_overrun), 0);
         if (c == 2 * STEP + 1)
            check($sformatf("v%0d_ovr_c19", id), int'(o_overrun),
                  (t.mode == 2) ? 1 : 0);
         if (o_busy !== 1'b1) busy_err++;
         if (o_done !== (c == LEN)) done_err++;
         if (t.mode == 2 && c >= 10) begin
            if (c == 10) begin
               h_idx = int'(o_res_idx);
               h_pk  = int'(o_res_peak);
            end
            if (!o_res_valid || int'(o_res_idx) != h_idx ||
                int'(o_res_peak) != h_pk)
               stab_err++;
         end
         collect(c);
         tick();
      end
      check($sformatf("v%0d_busy_end", id), int'(o_busy), 0);
      check($sformatf("v%0d_done_end", id), int'(o_done), 0);
      check($sformatf("v%0d_ovr_end", id), int'(o_overrun), int'(t.ovr));
      if (t.mode == 2) begin
         check($sformatf("v%0d_rv_held", id), int'(o_res_valid), 1);
         check($sformatf("v%0d_idx_held", id), int'(o_res_idx), 0);
         check($sformatf("v%0d_pk_held", id), int'(o_res_peak),
               int'(t.pk[0]));
         check($sformatf("v%0d_stable", id), stab_err, 0);
      end
      for (int j = 0; j < 4; j++) begin
         i_valid     = 1'b0;
         i_res_ready = !(t.mode == 2 && j == 0);
         collect(LEN + 1 + j);
         tick();
      end
      check($sformatf("v%0d_rv_drained", id), int'(o_res_valid), 0);
      check($sformatf("v%0d_busy_track", id), busy_err, 0);
      check($sformatf("v%0d_done_track", id), done_err, 0);
      check($sformatf("v%0d_n_res", id), n_got, t.n_res);
      for (int k = 0; k < t.n_res && k < n_got; k++) begin
         check($sformatf("v%0d_r%0d_idx", id, k), r_idx[k], k);
         check($sformatf("v%0d_r%0d_pk", id, k), r_pk[k], int'(t.pk[k]));
         if (t.mode == 0)
            check($sformatf("v%0d_r%0d_cyc", id, k), r_cyc[k],
                  10 + STEP * k);
      end
   endtask

   initial begin
      tbl[0].d[0] = '{16'd100, 16'd50, 16'hFED4, 16'd7,
                      16'd0, 16'd20, 16'd1, 16'd2};
      tbl[0].d[1] = '{8{16'h8000}};
      tbl[0].d[2] = '{8{16'd0}};
      tbl[0].v    = '{8'hFF, 8'hFF, 8'hFF};
      tbl[0].mode = 0;
      tbl[0].pk   = '{16'd300, 16'd32767, 16'd0};
      tbl[0].n_res = 3;
      tbl[0].ovr  = 1'b0;

      tbl[1].d[0] = '{16'd30000, 16'd30000, 16'd5, 16'd5,
                      16'd5, 16'd5, 16'd5, 16'd5};
      tbl[1].d[1] = '{16'd30000, 16'd30000, 16'hFFFB, 16'd5,
                      16'd5, 16'd5, 16'd5, 16'd5};
      tbl[1].d[2] = '{16'd1, 16'd1, 16'd1, 16'd1,
                      16'd1, 16'd1, 16'd1, 16'h8001};
      tbl[1].v    = '{8'hFF, 8'hFF, 8'hFF};
      tbl[1].mode = 0;
      tbl[1].pk   = '{16'd5, 16'd5, 16'd32767};
      tbl[1].n_res = 3;
      tbl[1].ovr  = 1'b0;

      tbl[2].d[0] = '{16'd0, 16'd0, 16'd10, 16'd20,
                      16'd30, 16'd40, 16'd50, 16'd60};
      tbl[2].d[1] = '{8{16'd1000}};
      tbl[2].d[2] = '{8{16'd1000}};
      tbl[2].v    = '{8'hFF, 8'hFF, 8'hFF};
      tbl[2].mode = 2;
      tbl[2].pk   = '{16'd60, 16'd1000, 16'd1000};
      tbl[2].n_res = 1;
      tbl[2].ovr  = 1'b1;

      tbl[3].d[0] = '{8{16'd11}};
      tbl[3].d[1] = '{8{16'hFFEA}};
      tbl[3].d[2] = '{8{16'd33}};
      tbl[3].v    = '{8'hFF, 8'hFF, 8'hFF};
      tbl[3].mode = 1;
      tbl[3].pk   = '{16'd11, 16'd22, 16'd33};
      tbl[3].n_res = 3;
      tbl[3].ovr  = 1'b0;

      tbl[4].d[0] = '{16'd1, 16'd2, 16'd3, 16'd900,
                      16'd4, 16'd5, 16'd6, 16'd7};
      tbl[4].d[1] = '{16'd0, 16'd0, 16'd800, 16'd1,
                      16'd2, 16'd3, 16'd4, 16'd5};
      tbl[4].d[2] = '{16'd9, 16'd9, 16'd9, 16'd9,
                      16'd9, 16'd9, 16'd9, 16'd700};
      tbl[4].v    = '{8'b1110_1111, 8'b1101_1111, 8'b1111_1110};
      tbl[4].mode = 0;
      tbl[4].pk   = '{16'd7, 16'd5, 16'd9};
      tbl[4].n_res = 3;
      tbl[4].ovr  = 1'b0;

      rst         = 1'b1;
      i_start     = 1'b0;
      i_data      = 16'd0;
      i_valid     = 1'b0;
      i_res_ready = 1'b1;
      repeat (3) tick();
      check("rst_busy", int'(o_busy), 0);
      check("rst_rv", int'(o_res_valid), 0);
      check("rst_pk", int'(o_res_peak), 0);
      check("rst_idx", int'(o_res_idx), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_ovr", int'(o_overrun), 0);
      rst = 1'b0;
      tick();
      check("idle_busy", int'(o_busy), 0);

      for (int i = 0; i < 5; i++) run_sweep(tbl[i], i);

      // reset mid-MEASURE of step 1 with step 0's result pending
      i_start     = 1'b1;
      i_res_ready = 1'b0;
      i_valid     = 1'b1;
      i_data      = 16'd0;
      tick();
      for (int c = 1; c <= 14; c++) begin
         i_start = (c == 3);
         i_data  = 16'(c * 10);
         rst     = (c == 14);
         if (c == 10) begin
            check("mid_rv_pending", int'(o_res_valid), 1);
            check("mid_idx_pending", int'(o_res_idx), 0);
            check("mid_pk_pending", int'(o_res_peak), 80);
         end
         tick();
      end
      rst     = 1'b0;
      i_start = 1'b0;
      i_valid = 1'b0;
      check("mid_rst_busy", int'(o_busy), 0);
      check("mid_rst_rv", int'(o_res_valid), 0);
      check("mid_rst_pk", int'(o_res_peak), 0);
      check("mid_rst_idx", int'(o_res_idx), 0);
      check("mid_rst_done", int'(o_done), 0);
      check("mid_rst_ovr", int'(o_overrun), 0);
      repeat (2) tick();
      check("mid_rst_stays_idle", int'(o_busy), 0);

      rst     = 1'b1;
      i_start = 1'b1;
      tick();
      rst     = 1'b0;
      i_start = 1'b0;
      check("rst_over_start", int'(o_busy), 0);
      tick();

      run_sweep(tbl[0], 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
